// File: rtl/fxp_addsub_pipe.sv
// Two-stage fixed-point add/subtract with format alignment, rounding, saturation,
// valid/ready handshakes and sticky overflow/underflow status for software readback.
module fxp_addsub_pipe #(
    parameter int I1    = 2,
    parameter int F1    = 14,
    parameter int I2    = 2,
    parameter int F2    = 14,
    parameter int I3    = 2,
    parameter int F3    = 13,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [I1+F1-1:0]   a,
    input  logic               s1,
    input  logic [I2+F2-1:0]   b,
    input  logic               s2,
    input  logic               sub,
    input  logic               rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [I3+F3-1:0]   c,
    output logic               sign,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr,
    output logic               ovf_sticky,
    output logic               unf_sticky,
    output logic [CNT_W-1:0]   sat_count
);
    localparam int W1  = I1 + F1;
    localparam int W2  = I2 + F2;
    localparam int W3  = I3 + F3;
    localparam int FM  = (F1 > F2) ? F1 : F2;
    localparam int IM  = ((I1 > I2) ? I1 : I2) + 1;
    localparam int WS  = IM + FM + 1;
    localparam int SH  = (FM > F3) ? FM - F3 : 0;
    localparam int PAD = (F3 > FM) ? F3 - FM : 0;
    localparam int WQ  = WS + 1 + PAD;
    localparam int WC  = (WQ > W3 + 1) ? WQ : W3 + 2;

    localparam logic signed [WQ-1:0] HALF =
        (SH > 0) ? (WQ'(1) <<< ((SH > 0) ? SH - 1 : 0)) : '0;
    localparam logic signed [WC-1:0] SMAX = (WC'(1) <<< (W3 - 1)) - WC'(1);
    localparam logic signed [WC-1:0] SMIN = ~SMAX;
    localparam logic signed [WC-1:0] UMAX = (WC'(1) <<< W3) - WC'(1);
    localparam logic [CNT_W-1:0]     CMAX = '1;

    // handshake
    logic s1_valid_q, out_valid_q;
    logic ld1, ld2, out_fire;

    assign out_fire = out_valid_q & out_ready;
    assign ld2      = ~out_valid_q | out_ready;
    assign ld1      = ~s1_valid_q | ld2;
    assign in_ready = ld1;

    // stage 1: exact aligned sum/difference
    logic [WS-1:0] a_x, b_x, sum_d, sum_q;
    logic          sgn1_q, rnd1_q;

    always_comb begin
        a_x   = {{(WS-W1){s1 & a[W1-1]}}, a} << (FM - F1);
        b_x   = {{(WS-W2){s2 & b[W2-1]}}, b} << (FM - F2);
        sum_d = sub ? (a_x - b_x) : (a_x + b_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            sum_q      <= '0;
            sgn1_q     <= 1'b0;
            rnd1_q     <= 1'b0;
        end else if (ld1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                sgn1_q <= s1 | s2 | sub;
                rnd1_q <= rnd;
            end
        end
    end

    // stage 2: quantise, then clamp to the output range
    logic signed [WQ-1:0] r_w, q_w;
    logic signed [WC-1:0] q_c;
    logic [W3-1:0]        c_d, c_q;
    logic                 ovf_d, unf_d, sign_q, ovf_q, unf_q;

    always_comb begin
        r_w   = WQ'($signed(sum_q));
        if (rnd1_q)
            r_w = r_w + HALF;
        q_w   = (r_w >>> SH) <<< PAD;
        q_c   = WC'(q_w);
        c_d   = q_c[W3-1:0];
        ovf_d = 1'b0;
        if (sgn1_q) begin
            if (q_c > SMAX) begin
                c_d   = {1'b0, {(W3-1){1'b1}}};
                ovf_d = 1'b1;
            end else if (q_c < SMIN) begin
                c_d   = {1'b1, {(W3-1){1'b0}}};
                ovf_d = 1'b1;
            end
        end else if (q_c > UMAX) begin
            c_d   = '1;
            ovf_d = 1'b1;
        end
        unf_d = (sum_q != '0) && (c_d == '0) && !ovf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (ld2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                c_q    <= c_d;
                sign_q <= sgn1_q;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    // status: clear takes effect before an event in the same cycle
    logic             ovf_st_d, ovf_st_q, unf_st_d, unf_st_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        ovf_st_d = ovf_st_q;
        unf_st_d = unf_st_q;
        cnt_d    = cnt_q;
        if (clr) begin
            ovf_st_d = 1'b0;
            unf_st_d = 1'b0;
            cnt_d    = '0;
        end
        if (out_fire) begin
            if (ovf_q) begin
                ovf_st_d = 1'b1;
                if (cnt_d != CMAX)
                    cnt_d = cnt_d + CNT_W'(1);
            end
            if (unf_q)
                unf_st_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_st_q <= 1'b0;
            unf_st_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ovf_st_q <= ovf_st_d;
            unf_st_q <= unf_st_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign c          = c_q;
    assign sign       = sign_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign ovf_sticky = ovf_st_q;
    assign unf_sticky = unf_st_q;
    assign sat_count  = cnt_q;
endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Bench for fxp_addsub_pipe: directed cases with literal results, then random
// traffic scored against an arithmetic reference model.
module tb_fxp_addsub_pipe;
    localparam int I1 = 2, F1 = 14, I2 = 2, F2 = 14, I3 = 2, F3 = 13, CNT_W = 16;
    localparam int W1 = I1 + F1, W2 = I2 + F2, W3 = I3 + F3;
    localparam int FM = (F1 > F2) ? F1 : F2;
    localparam int SHF = (FM > F3) ? FM - F3 : 0;
    localparam int PADF = (F3 > FM) ? F3 - FM : 0;

    logic clk, rst_n, in_valid, in_ready, s1, s2, sub, rnd;
    logic out_valid, out_ready, sign, overflow, underflow, clr, ovf_sticky, unf_sticky;
    logic [W1-1:0] a;
    logic [W2-1:0] b;
    logic [W3-1:0] c;
    logic [CNT_W-1:0] sat_count;

    fxp_addsub_pipe #(.I1(I1), .F1(F1), .I2(I2), .F2(F2), .I3(I3), .F3(F3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .s1(s1), .b(b), .s2(s2), .sub(sub), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .sign(sign),
        .overflow(overflow), .underflow(underflow), .clr(clr),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .sat_count(sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W3-1:0] c;
        logic sgn, ovf, unf;
    } exp_t;

    exp_t sbq[$];
    int n_chk = 0, n_fail = 0;
    logic m_ovf = 0, m_unf = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic got_rdy, got_out, hold_pend = 0;
    logic [W3-1:0] got_c;
    logic [2:0] got_f;
    logic [31:0] hold_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: real-valued arithmetic in units of 2^-FM, floor/round, clamp
    function automatic exp_t model(input logic [W1-1:0] ai, input logic [W2-1:0] bi,
                                   input logic s1i, s2i, subi, rndi);
        exp_t e;
        longint va, vb, ex, d, q, lo, hi;
        va = s1i ? longint'($signed(ai)) : longint'(ai);
        vb = s2i ? longint'($signed(bi)) : longint'(bi);
        va = va * (longint'(1) << (FM - F1));
        vb = vb * (longint'(1) << (FM - F2));
        ex = subi ? va - vb : va + vb;
        d  = longint'(1) << SHF;
        q  = ex + (rndi ? d / 2 : 0);
        if (q < 0 && (q % d) != 0) q = q / d - 1;
        else q = q / d;
        q = q * (longint'(1) << PADF);
        e.sgn = s1i | s2i | subi;
        hi = e.sgn ? (longint'(1) << (W3 - 1)) - 1 : (longint'(1) << W3) - 1;
        lo = e.sgn ? -(longint'(1) << (W3 - 1)) : 0;
        e.ovf = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        e.c   = W3'(q);
        e.unf = (ex != 0) && (q == 0) && !e.ovf;
        return e;
    endfunction

    task automatic cycle(input logic iv, input logic [W1-1:0] ai, input logic [W2-1:0] bi,
                         input logic s1i, s2i, subi, rndi, ordy, clri);
        exp_t e;
        logic fire;
        @(negedge clk);
        in_valid = iv; a = ai; b = bi; s1 = s1i; s2 = s2i; sub = subi; rnd = rndi;
        out_ready = ordy; clr = clri;
        #1;
        got_rdy = in_ready;
        got_out = 0;
        chk("ovf_sticky", ovf_sticky, m_ovf);
        chk("unf_sticky", unf_sticky, m_unf);
        chk("sat_count", sat_count, m_cnt);
        if (hold_pend) chk("hold", {out_valid, sign, overflow, underflow, c}, hold_v);
        hold_pend = out_valid && !out_ready;
        hold_v = {1'b1, sign, overflow, underflow, c};
        fire = 0;
        if (out_valid && out_ready) begin
            got_out = 1; got_c = c; got_f = {sign, overflow, underflow};
            if (sbq.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = sbq.pop_front();
                fire = 1;
                chk("c", c, e.c);
                chk("flags", {sign, overflow, underflow}, {e.sgn, e.ovf, e.unf});
            end
        end
        if (in_valid && in_ready) sbq.push_back(model(ai, bi, s1i, s2i, subi, rndi));
        @(posedge clk);
        if (clri) begin m_ovf = 0; m_unf = 0; m_cnt = '0; end
        if (fire) begin
            if (e.ovf) begin
                m_ovf = 1;
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
            if (e.unf) m_unf = 1;
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 0, 0, ordy, 0);
    endtask

    // single beat on an empty pipe; output must appear on the second edge after accept
    task automatic one_beat(input string tag, input logic [W1-1:0] ai, input logic [W2-1:0] bi,
                            input logic s1i, s2i, subi, rndi,
                            input logic [W3-1:0] ec, input logic [2:0] ef);
        cycle(1, ai, bi, s1i, s2i, subi, rndi, 1, 0);
        chk({tag, "_acc"}, got_rdy, 1);
        idle(1, 1);
        chk({tag, "_early"}, got_out, 0);
        idle(1, 1);
        chk({tag, "_lat"}, got_out, 1);
        chk({tag, "_c"}, got_c, ec);
        chk({tag, "_f"}, got_f, ef);
    endtask

    logic rv, rs1, rs2, rsub, rrnd, hold;
    logic [W1-1:0] ra;
    logic [W2-1:0] rb;

    initial begin
        rst_n = 0; in_valid = 0; a = '0; b = '0; s1 = 0; s2 = 0; sub = 0; rnd = 0;
        out_ready = 0; clr = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_flags", {sign, overflow, underflow}, 0);
        chk("rst_status", {ovf_sticky, unf_sticky, sat_count}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;

        one_beat("uadd", 16'h4000, 16'h4000, 0, 0, 0, 0, 15'h4000, 3'b000);
        one_beat("uovf", 16'hC000, 16'hC000, 0, 0, 0, 0, 15'h7FFF, 3'b010);
        #1 chk("uovf_cnt", sat_count, 1);
        chk("uovf_sticky", ovf_sticky, 1);
        one_beat("sadd", 16'hC000, 16'hC000, 1, 1, 0, 0, 15'h4000, 3'b100);
        one_beat("sovf", 16'hA000, 16'hA000, 1, 1, 0, 0, 15'h4000, 3'b110);
        #1 chk("sovf_cnt", sat_count, 2);
        one_beat("unf0", 16'h0001, 16'h0000, 0, 0, 0, 0, 15'h0000, 3'b001);
        #1 chk("unf_sticky_lit", unf_sticky, 1);
        one_beat("rnd1", 16'h0001, 16'h0000, 0, 0, 0, 1, 15'h0001, 3'b000);
        one_beat("usub", 16'h4000, 16'h8000, 0, 0, 1, 0, 15'h6000, 3'b100);

        // backpressure: two beats fill the pipe, third waits
        cycle(1, 16'h1000, 16'h0, 0, 0, 0, 0, 0, 0); chk("bp_rdy1", got_rdy, 1);
        cycle(1, 16'h2000, 16'h0, 0, 0, 0, 0, 0, 0); chk("bp_rdy2", got_rdy, 1);
        cycle(1, 16'h3000, 16'h0, 0, 0, 0, 0, 0, 0); chk("bp_rdy3", got_rdy, 0);
        cycle(1, 16'h3000, 16'h0, 0, 0, 0, 0, 0, 0); chk("bp_rdy4", got_rdy, 0);
        chk("bp_queued", sbq.size(), 2);
        cycle(1, 16'h3000, 16'h0, 0, 0, 0, 0, 1, 0); chk("bp_out1", got_c, 15'h0800);
        idle(1, 1); chk("bp_out2", got_c, 15'h1000);
        idle(1, 1); chk("bp_out3", got_c, 15'h1800);
        chk("bp_drained", sbq.size(), 0);

        // clear alone wipes status
        one_beat("covf", 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 15'h7FFF, 3'b010);
        cycle(0, '0, '0, 0, 0, 0, 0, 1, 1);
        #1 chk("clr_status", {ovf_sticky, unf_sticky, sat_count}, 0);

        // random traffic, producer holds a refused beat
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rv = ($urandom_range(0, 9) < 7);
                ra = W1'($urandom); rb = W2'($urandom);
                if ($urandom_range(0, 7) == 0) begin ra = W1'($urandom_range(0, 3)); rb = '0; end
                rs1 = 1'($urandom); rs2 = 1'($urandom); rsub = 1'($urandom); rrnd = 1'($urandom);
            end
            cycle(rv, ra, rb, rs1, rs2, rsub, rrnd, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
            hold = rv && !got_rdy;
        end
        idle(6, 1);
        chk("rand_drained", sbq.size(), 0);

        // asynchronous reset mid-stream
        cycle(1, 16'hC000, 16'hC000, 0, 0, 0, 0, 0, 0);
        cycle(1, 16'hC000, 16'hC000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 in_valid = 0; rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_c", {sign, overflow, underflow, c}, 0);
        chk("arst_status", {ovf_sticky, unf_sticky, sat_count}, 0);
        sbq.delete(); m_ovf = 0; m_unf = 0; m_cnt = '0; hold_pend = 0;
        @(negedge clk) rst_n = 1;
        idle(3, 1);
        chk("arst_no_output", sbq.size(), 0);
        one_beat("post_rst", 16'h4000, 16'h4000, 0, 0, 0, 0, 15'h4000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
